// File: rtl/generic_rs.sv
// generic_rs: reservation station between the issue stage and one execution unit.
//   Buffers up to RS_DEPTH instructions, snoops the CDB for missing operands,
//   dispatches ready entries to the EU, collects EU results by entry index and
//   broadcasts them on the CDB before freeing the entry.
// Ports:
//   clk_i, rst_n_i, flush_i            clock, async active-low reset, sync clear
//   issue_*                            instruction offer from issue (valid/ready)
//   eu_valid_o/eu_ready_i, eu_ctl_o,
//   eu_rs1_o, eu_rs2_o, eu_entry_idx_o operand dispatch to the EU
//   eu_valid_i/eu_ready_o, eu_entry_idx_i,
//   eu_result_i, eu_except_*_i         result return from the EU
//   cdb_valid_i, cdb_idx_i, cdb_data_i CDB snoop side
//   cdb_valid_o/cdb_ready_i, cdb_idx_o,
//   cdb_data_o, cdb_except_*_o         CDB broadcast request

package generic_rs_pkg;
  typedef enum logic [4:0] {
    E_I_ADDR_MISALIGNED   = 5'd0,
    E_I_ACCESS_FAULT      = 5'd1,
    E_ILLEGAL_INSTRUCTION = 5'd2,
    E_BREAKPOINT          = 5'd3,
    E_LD_ADDR_MISALIGNED  = 5'd4,
    E_LD_ACCESS_FAULT     = 5'd5,
    E_SD_ADDR_MISALIGNED  = 5'd6,
    E_SD_ACCESS_FAULT     = 5'd7,
    E_UNKNOWN             = 5'd31
  } except_code_t;
endpackage

module generic_rs
  import generic_rs_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RS_DEPTH    = 4,
  parameter int unsigned EU_CTL_LEN  = 4,
  parameter int unsigned ROB_IDX_LEN = 5,
  localparam int unsigned IDX_W      = $clog2(RS_DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  // issue
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [EU_CTL_LEN-1:0]  issue_eu_ctl_i,
  input  logic                   issue_rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
  input  logic [XLEN-1:0]        issue_rs1_value_i,
  input  logic                   issue_rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
  input  logic [XLEN-1:0]        issue_rs2_value_i,
  input  logic [ROB_IDX_LEN-1:0] issue_dest_idx_i,
  // dispatch to EU
  input  logic                   eu_ready_i,
  output logic                   eu_valid_o,
  output logic [EU_CTL_LEN-1:0]  eu_ctl_o,
  output logic [XLEN-1:0]        eu_rs1_o,
  output logic [XLEN-1:0]        eu_rs2_o,
  output logic [IDX_W-1:0]       eu_entry_idx_o,
  // result from EU
  input  logic                   eu_valid_i,
  output logic                   eu_ready_o,
  input  logic [IDX_W-1:0]       eu_entry_idx_i,
  input  logic [XLEN-1:0]        eu_result_i,
  input  logic                   eu_except_raised_i,
  input  except_code_t           eu_except_code_i,
  // CDB snoop
  input  logic                   cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0] cdb_idx_i,
  input  logic [XLEN-1:0]        cdb_data_i,
  // CDB broadcast
  input  logic                   cdb_ready_i,
  output logic                   cdb_valid_o,
  output logic [ROB_IDX_LEN-1:0] cdb_idx_o,
  output logic [XLEN-1:0]        cdb_data_o,
  output logic                   cdb_except_raised_o,
  output except_code_t           cdb_except_code_o
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_WAIT_OPS,
    S_READY,
    S_EXEC,
    S_WAIT_CDB
  } state_t;

  typedef struct packed {
    state_t                   state;
    logic [EU_CTL_LEN-1:0]    ctl;
    logic                     rs1_ready;
    logic [ROB_IDX_LEN-1:0]   rs1_idx;
    logic [XLEN-1:0]          rs1_value;
    logic                     rs2_ready;
    logic [ROB_IDX_LEN-1:0]   rs2_idx;
    logic [XLEN-1:0]          rs2_value;
    logic [ROB_IDX_LEN-1:0]   dest_idx;
    logic [XLEN-1:0]          result;
    logic                     except_raised;
    except_code_t             except_code;
  } entry_t;

  function automatic entry_t entry_reset();
    entry_t e;
    e             = '0;
    e.state       = S_EMPTY;
    e.except_code = E_UNKNOWN;
    return e;
  endfunction

  entry_t entry_q [RS_DEPTH];
  entry_t entry_d [RS_DEPTH];

  logic             alloc_found, disp_found, cdb_found;
  logic [IDX_W-1:0] alloc_idx, disp_idx, cdb_sel;
  logic             alloc_fire, disp_fire, cdb_fire;
  logic             issue_rs1_snoop, issue_rs2_snoop;

  // Lowest-index selection for allocation, dispatch and writeback.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    disp_found  = 1'b0;
    disp_idx    = '0;
    cdb_found   = 1'b0;
    cdb_sel     = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (!alloc_found && entry_q[i].state == S_EMPTY) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (!disp_found && entry_q[i].state == S_READY) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      if (!cdb_found && entry_q[i].state == S_WAIT_CDB) begin
        cdb_found = 1'b1;
        cdb_sel   = IDX_W'(i);
      end
    end
  end

  assign issue_ready_o = alloc_found;
  assign eu_valid_o    = disp_found;
  assign cdb_valid_o   = cdb_found;
  assign eu_ready_o    = 1'b1;

  assign alloc_fire = issue_valid_i && alloc_found;
  assign disp_fire  = disp_found && eu_ready_i;
  assign cdb_fire   = cdb_found && cdb_ready_i;

  // A broadcast in the allocation cycle is captured directly from the CDB.
  assign issue_rs1_snoop = cdb_valid_i && (cdb_idx_i == issue_rs1_idx_i);
  assign issue_rs2_snoop = cdb_valid_i && (cdb_idx_i == issue_rs2_idx_i);

  // Dispatch and writeback datapaths; idle outputs are forced to reset values.
  always_comb begin
    eu_ctl_o            = '0;
    eu_rs1_o            = '0;
    eu_rs2_o            = '0;
    cdb_idx_o           = '0;
    cdb_data_o          = '0;
    cdb_except_raised_o = 1'b0;
    cdb_except_code_o   = E_UNKNOWN;
    if (disp_found) begin
      eu_ctl_o = entry_q[disp_idx].ctl;
      eu_rs1_o = entry_q[disp_idx].rs1_value;
      eu_rs2_o = entry_q[disp_idx].rs2_value;
    end
    if (cdb_found) begin
      cdb_idx_o           = entry_q[cdb_sel].dest_idx;
      cdb_data_o          = entry_q[cdb_sel].result;
      cdb_except_raised_o = entry_q[cdb_sel].except_raised;
      cdb_except_code_o   = entry_q[cdb_sel].except_code;
    end
  end
  assign eu_entry_idx_o = disp_idx;

  // Per-entry next state. Alloc, dispatch, result and free each act on a
  // different state, so they never collide on one entry and commit together.
  always_comb begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      entry_d[i] = entry_q[i];

      if (entry_q[i].state == S_WAIT_OPS) begin
        if (!entry_q[i].rs1_ready && cdb_valid_i && cdb_idx_i == entry_q[i].rs1_idx) begin
          entry_d[i].rs1_ready = 1'b1;
          entry_d[i].rs1_value = cdb_data_i;
        end
        if (!entry_q[i].rs2_ready && cdb_valid_i && cdb_idx_i == entry_q[i].rs2_idx) begin
          entry_d[i].rs2_ready = 1'b1;
          entry_d[i].rs2_value = cdb_data_i;
        end
        if (entry_d[i].rs1_ready && entry_d[i].rs2_ready) begin
          entry_d[i].state = S_READY;
        end
      end

      if (alloc_fire && alloc_idx == IDX_W'(i)) begin
        entry_d[i]           = entry_reset();
        entry_d[i].ctl       = issue_eu_ctl_i;
        entry_d[i].rs1_idx   = issue_rs1_idx_i;
        entry_d[i].rs1_ready = issue_rs1_ready_i || issue_rs1_snoop;
        entry_d[i].rs1_value = issue_rs1_ready_i ? issue_rs1_value_i : cdb_data_i;
        entry_d[i].rs2_idx   = issue_rs2_idx_i;
        entry_d[i].rs2_ready = issue_rs2_ready_i || issue_rs2_snoop;
        entry_d[i].rs2_value = issue_rs2_ready_i ? issue_rs2_value_i : cdb_data_i;
        entry_d[i].dest_idx  = issue_dest_idx_i;
        entry_d[i].state     = (entry_d[i].rs1_ready && entry_d[i].rs2_ready)
                               ? S_READY : S_WAIT_OPS;
      end

      if (disp_fire && disp_idx == IDX_W'(i)) begin
        entry_d[i].state = S_EXEC;
      end

      // Results for entries not in EXEC are dropped.
      if (eu_valid_i && eu_entry_idx_i == IDX_W'(i) && entry_q[i].state == S_EXEC) begin
        entry_d[i].result        = eu_result_i;
        entry_d[i].except_raised = eu_except_raised_i;
        entry_d[i].except_code   = eu_except_code_i;
        entry_d[i].state         = S_WAIT_CDB;
      end

      if (cdb_fire && cdb_sel == IDX_W'(i)) begin
        entry_d[i] = entry_reset();
      end

      if (flush_i) begin
        entry_d[i] = entry_reset();
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= entry_reset();
      end
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  logic result_targets_exec;
  assign result_targets_exec = (entry_q[eu_entry_idx_i].state == S_EXEC);

  a_result_targets_exec: assert property (
    @(posedge clk_i) disable iff (!rst_n_i || flush_i)
      eu_valid_i |-> result_targets_exec
  );

endmodule

// File: tb/tb_generic_rs.sv
// tb_generic_rs: directed self-checking bench for generic_rs (RS_DEPTH=4, XLEN=32).
module tb_generic_rs;
  import generic_rs_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         issue_valid;
  logic         issue_ready;
  logic [3:0]   issue_eu_ctl;
  logic         issue_rs1_ready, issue_rs2_ready;
  logic [4:0]   issue_rs1_idx, issue_rs2_idx, issue_dest_idx;
  logic [31:0]  issue_rs1_value, issue_rs2_value;
  logic         eu_ready_in, eu_valid_out;
  logic [3:0]   eu_ctl;
  logic [31:0]  eu_rs1, eu_rs2;
  logic [1:0]   eu_entry_idx_out;
  logic         eu_valid_in, eu_ready_out;
  logic [1:0]   eu_entry_idx_in;
  logic [31:0]  eu_result;
  logic         eu_except_raised;
  except_code_t eu_except_code;
  logic         cdb_valid_in;
  logic [4:0]   cdb_idx_in;
  logic [31:0]  cdb_data_in;
  logic         cdb_ready_in, cdb_valid_out;
  logic [4:0]   cdb_idx_out;
  logic [31:0]  cdb_data_out;
  logic         cdb_except_raised;
  except_code_t cdb_except_code;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  generic_rs #(
    .XLEN(32), .RS_DEPTH(4), .EU_CTL_LEN(4), .ROB_IDX_LEN(5)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_eu_ctl_i(issue_eu_ctl),
    .issue_rs1_ready_i(issue_rs1_ready), .issue_rs1_idx_i(issue_rs1_idx),
    .issue_rs1_value_i(issue_rs1_value),
    .issue_rs2_ready_i(issue_rs2_ready), .issue_rs2_idx_i(issue_rs2_idx),
    .issue_rs2_value_i(issue_rs2_value),
    .issue_dest_idx_i(issue_dest_idx),
    .eu_ready_i(eu_ready_in), .eu_valid_o(eu_valid_out), .eu_ctl_o(eu_ctl),
    .eu_rs1_o(eu_rs1), .eu_rs2_o(eu_rs2), .eu_entry_idx_o(eu_entry_idx_out),
    .eu_valid_i(eu_valid_in), .eu_ready_o(eu_ready_out),
    .eu_entry_idx_i(eu_entry_idx_in), .eu_result_i(eu_result),
    .eu_except_raised_i(eu_except_raised), .eu_except_code_i(eu_except_code),
    .cdb_valid_i(cdb_valid_in), .cdb_idx_i(cdb_idx_in), .cdb_data_i(cdb_data_in),
    .cdb_ready_i(cdb_ready_in), .cdb_valid_o(cdb_valid_out),
    .cdb_idx_o(cdb_idx_out), .cdb_data_o(cdb_data_out),
    .cdb_except_raised_o(cdb_except_raised), .cdb_except_code_o(cdb_except_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [31:0] ctl,
                          input logic r1_rdy, input logic [31:0] r1_tag, input logic [31:0] r1_val,
                          input logic r2_rdy, input logic [31:0] r2_tag, input logic [31:0] r2_val,
                          input logic [31:0] dest);
    issue_eu_ctl    = ctl[3:0];
    issue_rs1_ready = r1_rdy;
    issue_rs1_idx   = r1_tag[4:0];
    issue_rs1_value = r1_val;
    issue_rs2_ready = r2_rdy;
    issue_rs2_idx   = r2_tag[4:0];
    issue_rs2_value = r2_val;
    issue_dest_idx  = dest[4:0];
    issue_valid     = 1'b1;
    tick();
    issue_valid     = 1'b0;
  endtask

  task automatic eu_return(input logic [31:0] idx, input logic [31:0] res,
                           input logic exc, input except_code_t code);
    eu_valid_in      = 1'b1;
    eu_entry_idx_in  = idx[1:0];
    eu_result        = res;
    eu_except_raised = exc;
    eu_except_code   = code;
    tick();
    eu_valid_in      = 1'b0;
    eu_except_raised = 1'b0;
    eu_except_code   = E_UNKNOWN;
  endtask

  task automatic drain_cdb();
    cdb_ready_in = 1'b1;
    tick();
    cdb_ready_in = 1'b0;
  endtask

  task automatic dispatch_one();
    eu_ready_in = 1'b1;
    tick();
    eu_ready_in = 1'b0;
  endtask

  // Leaves entry0 WAIT_CDB, entry1 EXEC, entry2 READY, entry3 WAIT_OPS.
  task automatic build_all_states();
    eu_ready_in = 1'b0;
    do_issue(1, 1, 0, 32'h100, 1, 0, 32'h200, 1);
    dispatch_one();
    eu_return(0, 32'h300, 1'b0, E_UNKNOWN);
    do_issue(2, 1, 0, 32'h101, 1, 0, 32'h201, 2);
    dispatch_one();
    do_issue(3, 1, 0, 32'h102, 1, 0, 32'h202, 3);
    do_issue(4, 1, 0, 32'h103, 0, 9, 0, 4);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_issue_ready"}, issue_ready, 1);
    chk({tag, "_eu_valid"}, eu_valid_out, 0);
    chk({tag, "_cdb_valid"}, cdb_valid_out, 0);
    chk({tag, "_cdb_data"}, cdb_data_out, 0);
    chk({tag, "_cdb_code"}, cdb_except_code, E_UNKNOWN);
    chk({tag, "_eu_rs1"}, eu_rs1, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_eu_ctl = '0;
    issue_rs1_ready = 1'b0; issue_rs1_idx = '0; issue_rs1_value = '0;
    issue_rs2_ready = 1'b0; issue_rs2_idx = '0; issue_rs2_value = '0;
    issue_dest_idx = '0;
    eu_ready_in = 1'b0; eu_valid_in = 1'b0; eu_entry_idx_in = '0; eu_result = '0;
    eu_except_raised = 1'b0; eu_except_code = E_UNKNOWN;
    cdb_valid_in = 1'b0; cdb_idx_in = '0; cdb_data_in = '0; cdb_ready_in = 1'b0;

    repeat (3) tick();
    chk_idle("rst");
    chk("rst_eu_ready_o", eu_ready_out, 1);
    rst_n = 1'b1;
    tick();

    // 1: basic issue -> dispatch -> result -> broadcast
    eu_ready_in     = 1'b1;
    issue_eu_ctl    = 4'h3;
    issue_rs1_ready = 1'b1; issue_rs1_value = 6;
    issue_rs2_ready = 1'b1; issue_rs2_value = 3;
    issue_dest_idx  = 5;
    issue_valid     = 1'b1;
    #1;
    chk("t1_issue_ready", issue_ready, 1);
    chk("t1_no_same_cycle_dispatch", eu_valid_out, 0);
    tick();
    issue_valid = 1'b0;
    chk("t1_eu_valid", eu_valid_out, 1);
    chk("t1_eu_rs1", eu_rs1, 6);
    chk("t1_eu_rs2", eu_rs2, 3);
    chk("t1_eu_ctl", eu_ctl, 3);
    chk("t1_eu_idx", eu_entry_idx_out, 0);
    tick();
    chk("t1_exec_no_eu_valid", eu_valid_out, 0);
    chk("t1_exec_no_cdb_valid", cdb_valid_out, 0);
    eu_return(0, 2, 1'b0, E_UNKNOWN);
    chk("t1_cdb_valid", cdb_valid_out, 1);
    chk("t1_cdb_data", cdb_data_out, 2);
    chk("t1_cdb_idx", cdb_idx_out, 5);
    chk("t1_cdb_exc", cdb_except_raised, 0);
    drain_cdb();
    chk("t1_freed", cdb_valid_out, 0);

    // 2: operand wakeup through CDB snoop
    do_issue(1, 1, 0, 4, 0, 7, 0, 8);
    chk("t2_wait_no_dispatch", eu_valid_out, 0);
    cdb_valid_in = 1'b1; cdb_idx_in = 6; cdb_data_in = 99;
    tick();
    chk("t2_other_tag_ignored", eu_valid_out, 0);
    cdb_idx_in = 7; cdb_data_in = 9;
    tick();
    cdb_valid_in = 1'b0;
    chk("t2_wakeup_dispatch", eu_valid_out, 1);
    chk("t2_eu_rs2", eu_rs2, 9);
    chk("t2_eu_rs1", eu_rs1, 4);
    tick();
    eu_return(0, 32'h13, 1'b0, E_UNKNOWN);
    chk("t2_cdb_data", cdb_data_out, 32'h13);
    chk("t2_cdb_idx", cdb_idx_out, 8);
    drain_cdb();

    // 2b: broadcast in the allocation cycle
    cdb_valid_in = 1'b1; cdb_idx_in = 3; cdb_data_in = 32'h21;
    do_issue(2, 0, 3, 0, 1, 0, 11, 10);
    cdb_valid_in = 1'b0;
    chk("t2b_dispatch", eu_valid_out, 1);
    chk("t2b_eu_rs1", eu_rs1, 32'h21);
    chk("t2b_eu_rs2", eu_rs2, 11);
    tick();
    eu_return(0, 32'h44, 1'b0, E_UNKNOWN);
    chk("t2b_cdb_idx", cdb_idx_out, 10);
    drain_cdb();

    // 3: fill all entries
    eu_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_ready_while_filling", issue_ready, 1);
      do_issue(k, 1, 0, 16 + k, 1, 0, 32 + k, 20 + k);
    end
    chk("t3_full", issue_ready, 0);
    issue_rs1_value = 32'hAA; issue_dest_idx = 30;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("t3_fifth_ignored_idx", eu_entry_idx_out, 0);
    chk("t3_fifth_ignored_rs1", eu_rs1, 16);
    chk("t3_still_full", issue_ready, 0);
    dispatch_one();
    chk("t3_next_lowest_ready", eu_entry_idx_out, 1);
    chk("t3_exec_not_free", issue_ready, 0);
    eu_return(0, 32'h55, 1'b0, E_UNKNOWN);
    chk("t3_cdb_data", cdb_data_out, 32'h55);
    chk("t3_cdb_idx", cdb_idx_out, 20);
    cdb_ready_in = 1'b1;
    #1;
    chk("t3_no_same_cycle_free", issue_ready, 0);
    tick();
    cdb_ready_in = 1'b0;
    chk("t3_ready_after_free", issue_ready, 1);

    // 4: writeback order and hold under back-pressure
    eu_ready_in = 1'b1;
    #1;
    chk("t4_disp_idx1", eu_entry_idx_out, 1);
    tick();
    chk("t4_disp_idx2", eu_entry_idx_out, 2);
    tick();
    eu_ready_in = 1'b0;
    eu_return(2, 32'h22, 1'b0, E_UNKNOWN);
    eu_return(1, 32'h11, 1'b0, E_UNKNOWN);
    for (int c = 0; c < 3; c++) begin
      chk("t4_hold_valid", cdb_valid_out, 1);
      chk("t4_hold_data", cdb_data_out, 32'h11);
      chk("t4_hold_idx", cdb_idx_out, 21);
      tick();
    end
    cdb_ready_in = 1'b1;
    #1;
    chk("t4_first_data", cdb_data_out, 32'h11);
    tick();
    chk("t4_second_data", cdb_data_out, 32'h22);
    chk("t4_second_idx", cdb_idx_out, 22);
    tick();
    cdb_ready_in = 1'b0;
    chk("t4_drained", cdb_valid_out, 0);

    // 5: exception propagation (entry 3 still READY)
    chk("t5_eu_rs1", eu_rs1, 19);
    chk("t5_eu_ctl", eu_ctl, 3);
    dispatch_one();
    eu_return(3, 32'h77, 1'b1, E_ILLEGAL_INSTRUCTION);
    chk("t5_cdb_exc", cdb_except_raised, 1);
    chk("t5_cdb_code", cdb_except_code, E_ILLEGAL_INSTRUCTION);
    chk("t5_cdb_idx", cdb_idx_out, 23);
    drain_cdb();
    chk("t5_empty", issue_ready, 1);

    // 6a: flush with entries in every state and competing events
    build_all_states();
    chk("t6_full", issue_ready, 0);
    chk("t6_eu_valid", eu_valid_out, 1);
    chk("t6_cdb_valid", cdb_valid_out, 1);
    flush = 1'b1; issue_valid = 1'b1; cdb_ready_in = 1'b1;
    eu_valid_in = 1'b1; eu_entry_idx_in = 1; eu_result = 32'hDEAD;
    cdb_valid_in = 1'b1; cdb_idx_in = 9; cdb_data_in = 5;
    tick();
    issue_valid = 1'b0; cdb_ready_in = 1'b0; cdb_valid_in = 1'b0;
    chk_idle("t6_flush");
    tick();
    flush = 1'b0; eu_valid_in = 1'b0;
    chk("t6_late_result_dropped", cdb_valid_out, 0);

    // 6b: asynchronous reset with entries in every state
    build_all_states();
    rst_n = 1'b0;
    #1;
    chk_idle("t6_async_rst");
    eu_valid_in = 1'b1; eu_entry_idx_in = 1; eu_result = 32'hBEEF;
    tick();
    eu_valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("t6_after_rst");

    // sanity after reset: allocation restarts at entry 0
    do_issue(5, 1, 0, 32'h5A, 1, 0, 32'hA5, 17);
    chk("post_idx", eu_entry_idx_out, 0);
    chk("post_rs1", eu_rs1, 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
